uart_tx: RTL

//  Synthesizable 8-data-bit, no-parity UART transmitter: the sending end of the serial link that
//  the SoC's uart_srx input receives. Bytes are pushed over a valid/ready handshake into a small

---
 rtl/uart_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter: bytes enter a small FIFO over valid/ready and are
// serialized LSB-first onto tx_out. Back-to-back frames go out with no idle gap.
module uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [PTR_W:0]    FULL      = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;

  state_t            state;
  state_t            state_nxt;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              bit_end;
  logic              tx_nxt;
  logic              busy_nxt;

  // Ready comes from the registered count only, so a full FIFO never accepts
  // a byte even on the edge that pops one.
  assign tx_ready   = (count != FULL);
  assign push       = tx_valid && tx_ready;
  assign fifo_level = count;
  assign bit_end    = (baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // State register plus the baud/bit counters and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state  <= state_nxt;
      tx_out <= tx_nxt;
      busy   <= busy_nxt;
      baud   <= (state == IDLE || bit_end) ? '0 : baud + BAUD_W'(1);
      if (bit_end && state == DATA)
        bit_cnt <= bit_cnt + 3'd1;
      else if (bit_end && state == STOP)
        bit_cnt <= (bit_cnt == STOP_LAST) ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  // Shift register is loaded only on a pop; later tx_data changes cannot leak in.
  always_ff @(posedge clk) begin
    if (pop)
      shift <= mem[rd_ptr];
    else if (state == DATA && bit_end)
      shift <= {1'b0, shift[7:1]};
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      START:
        if (bit_end) state_nxt = DATA;
      DATA:
        if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:
        if (bit_end && bit_cnt == STOP_LAST) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = (state == START) ? shift[0] : (bit_end ? shift[1] : tx_out);
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule
